// File: rtl/cgra_rd_arb_pkg.sv
// Shared types and constants for the CGRA read-channel arbiter.
// Default sizing matches the 4 input nodes plus the configuration loader.
package cgra_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF = 5;
  localparam int IDX_W       = $clog2(NUM_REQ_DEF);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cgra_idx_fifo.sv
// In-order FIFO of requester indices for outstanding reads; depth must be a power of 2.
// Pointers wrap naturally at DEPTH, the count distinguishes full from empty.
module cgra_idx_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk_i) begin
    if (push_en && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cgra_rd_arbiter.sv
// Round-robin sharing of the CGRA AXI-Lite read channel among NUM_REQ streamers.
// Define CGRA_RD_ARB_PERF_EN to add per-requester grant counters and a full-stall counter.
module cgra_rd_arbiter
  import cgra_rd_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_ar_addr_i,
  input  logic [NUM_REQ-1:0]            req_ar_valid_i,
  output logic [NUM_REQ-1:0]            req_ar_ready_o,
  output logic [DATA_WIDTH-1:0]         req_r_data_o,
  output logic [1:0]                    req_r_resp_o,
  output logic [NUM_REQ-1:0]            req_r_valid_o,
  input  logic [NUM_REQ-1:0]            req_r_ready_i,
  output logic [ADDR_WIDTH-1:0]         mst_ar_addr_o,
  output logic                          mst_ar_valid_o,
  input  logic                          mst_ar_ready_i,
  input  logic [DATA_WIDTH-1:0]         mst_r_data_i,
  input  logic [1:0]                    mst_r_resp_i,
  input  logic                          mst_r_valid_i,
  output logic                          mst_r_ready_o,
  output logic                          outst_full_o,
  output logic                          proto_err_o
`ifdef CGRA_RD_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]         grant_cnt_o,
  output logic [31:0]                   wait_cnt_o
`endif
);

  localparam int REQ_IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W     = $clog2(MAX_OUTST + 1);

  arb_state_e             state_q, state_d;
  logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [REQ_IDX_W-1:0]   win_idx_q, win_idx_d;
  logic [ADDR_WIDTH-1:0]  ar_addr_q, ar_addr_d;
  logic                   ar_valid_q, ar_valid_d;
  logic                   proto_err_q, proto_err_d;

  logic                   grant_found;
  logic [REQ_IDX_W-1:0]   grant_idx;
  logic                   can_grant;
  logic                   ar_hs;
  logic                   r_pop;
  logic [REQ_IDX_W-1:0]   head_idx;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  int                     cand;

  // Search starts at rr_ptr and wraps, so the last winner becomes lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_ar_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = REQ_IDX_W'(cand);
      end
    end
  end

  assign can_grant = (state_q == IDLE) && grant_found && !clear_i && !rst_i &&
                     (fifo_count < CNT_W'(MAX_OUTST));
  assign ar_hs     = ar_valid_q && mst_ar_ready_i;

  always_comb begin
    req_ar_ready_o = '0;
    if (can_grant) req_ar_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_idx_d   = win_idx_q;
    ar_addr_d   = ar_addr_q;
    ar_valid_d  = ar_valid_q;
    proto_err_d = proto_err_q | (mst_r_valid_i && fifo_empty);
    unique case (state_q)
      IDLE: begin
        if (can_grant) begin
          state_d    = ISSUE;
          win_idx_d  = grant_idx;
          ar_addr_d  = req_ar_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          ar_valid_d = 1'b1;
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          state_d    = IDLE;
          ar_valid_d = 1'b0;
          rr_ptr_d   = (int'(win_idx_q) == NUM_REQ - 1) ? '0 : win_idx_q + REQ_IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d     = IDLE;
      rr_ptr_d    = '0;
      win_idx_d   = '0;
      ar_addr_d   = '0;
      ar_valid_d  = 1'b0;
      proto_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_idx_q   <= '0;
      ar_addr_q   <= '0;
      ar_valid_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_idx_q   <= win_idx_d;
      ar_addr_q   <= ar_addr_d;
      ar_valid_q  <= ar_valid_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mst_ar_addr_o  = ar_addr_q;
  assign mst_ar_valid_o = ar_valid_q;
  assign proto_err_o    = proto_err_q;
  assign outst_full_o   = fifo_full;

  cgra_idx_fifo #(
    .WIDTH (REQ_IDX_W),
    .DEPTH (MAX_OUTST)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (ar_hs),
    .data_i  (win_idx_q),
    .pop_i   (r_pop),
    .data_o  (head_idx),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // R beats belong to the oldest outstanding read; with nothing outstanding they are refused.
  always_comb begin
    req_r_valid_o = '0;
    mst_r_ready_o = 1'b0;
    if (!fifo_empty) begin
      req_r_valid_o[head_idx] = mst_r_valid_i;
      mst_r_ready_o           = req_r_ready_i[head_idx];
    end
  end

  assign r_pop        = mst_r_valid_i && mst_r_ready_o;
  assign req_r_data_o = mst_r_data_i;
  assign req_r_resp_o = mst_r_resp_i;

`ifdef CGRA_RD_ARB_PERF_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] grant_cnt_d [NUM_REQ];
  logic [31:0] wait_cnt_q, wait_cnt_d;

  // Both counters saturate instead of wrapping so software never sees a false small value.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (req_ar_ready_o[i] && (grant_cnt_q[i] != 32'hFFFF_FFFF))
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      if (clear_i) grant_cnt_d[i] = '0;
    end
    wait_cnt_d = wait_cnt_q;
    if ((|req_ar_valid_i) && fifo_full && (wait_cnt_q != 32'hFFFF_FFFF))
      wait_cnt_d = wait_cnt_q + 32'd1;
    if (clear_i) wait_cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      wait_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
      wait_cnt_q <= wait_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
    assign grant_cnt_o[g*32 +: 32] = grant_cnt_q[g];
  end
  assign wait_cnt_o = wait_cnt_q;
`endif

endmodule

// File: tb/tb_cgra_rd_arbiter.sv
// Scoreboard bench for cgra_rd_arbiter: directed vectors push expected grants,
// AR addresses and R beats; a negedge monitor pops and compares on every DUT handshake.
module tb_cgra_rd_arbiter;
   import cgra_rd_arb_pkg::*;

   typedef struct {
      logic [4:0]  oneHot;
      logic [31:0] data;
      logic [1:0]  resp;
   } rExp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         clr = 1'b0;
   logic [159:0] reqArAddr;
   logic [4:0]   reqArValid = '0;
   logic [4:0]   reqArReady;
   logic [31:0]  reqRData;
   logic [1:0]   reqRResp;
   logic [4:0]   reqRValid;
   logic [4:0]   reqRReady = '0;
   logic [31:0]  mstArAddr;
   logic         mstArValid;
   logic         mstArReady = 1'b0;
   logic [31:0]  mstRData = '0;
   logic [1:0]   mstRResp = '0;
   logic         mstRValid = 1'b0;
   logic         mstRReady;
   logic         outstFull;
   logic         protoErr;

   logic [31:0]  addrTab [5];
   int           grantQ [$];
   logic [31:0]  arQ [$];
   rExp_t        rQ [$];
   int           nVectors = 0;
   int           nMiss = 0;
   int           cycleCnt = 0;
   int           lastGrant = 0;
   logic         havePrev = 1'b0;
   logic         spacingOn = 1'b0;

   cgra_rd_arbiter dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .clear_i        (clr),
      .req_ar_addr_i  (reqArAddr),
      .req_ar_valid_i (reqArValid),
      .req_ar_ready_o (reqArReady),
      .req_r_data_o   (reqRData),
      .req_r_resp_o   (reqRResp),
      .req_r_valid_o  (reqRValid),
      .req_r_ready_i  (reqRReady),
      .mst_ar_addr_o  (mstArAddr),
      .mst_ar_valid_o (mstArValid),
      .mst_ar_ready_i (mstArReady),
      .mst_r_data_i   (mstRData),
      .mst_r_resp_i   (mstRResp),
      .mst_r_valid_i  (mstRValid),
      .mst_r_ready_o  (mstRReady),
      .outst_full_o   (outstFull),
      .proto_err_o    (protoErr)
   );

   // 10 ns clock; the cycle counter lets the monitor measure grant spacing
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   always_comb begin
      for (int i = 0; i < 5; i++) reqArAddr[i*32 +: 32] = addrTab[i];
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic reportUnexpected(input string name, input logic [63:0] act);
      nVectors++;
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected no event", name, act);
   endtask

   // Inputs change 2 ns after the rising edge; direct checks happen at +4 ns
   task automatic applyStimulus(input logic [4:0] arValid, input logic arRdy, input logic rValid,
                                input logic [31:0] rData, input logic [1:0] rResp,
                                input logic [4:0] rRdy);
      @(posedge clk);
      #2;
      reqArValid = arValid;
      mstArReady = arRdy;
      mstRValid  = rValid;
      mstRData   = rData;
      mstRResp   = rResp;
      reqRReady  = rRdy;
      #2;
   endtask

   // Monitor: pops the scoreboard whenever the DUT grants, issues an AR, or delivers an R beat
   always @(negedge clk) begin
      if (!spacingOn) havePrev <= 1'b0;
      if (!rst) begin
         if (|reqArReady) begin
            if (grantQ.size() == 0) reportUnexpected("unexpected_grant", reqArReady);
            else checkOutput("grant_order", reqArReady, 64'(5'b1 << grantQ.pop_front()));
            if (spacingOn && havePrev) checkOutput("grant_spacing", cycleCnt - lastGrant, 2);
            if (spacingOn) begin
               lastGrant <= cycleCnt;
               havePrev  <= 1'b1;
            end
         end
         if (mstArValid && mstArReady) begin
            if (arQ.size() == 0) reportUnexpected("unexpected_ar", mstArAddr);
            else checkOutput("ar_addr", mstArAddr, arQ.pop_front());
         end
         if (mstRValid && mstRReady) begin
            if (rQ.size() == 0) reportUnexpected("unexpected_r", reqRValid);
            else begin
               rExp_t e;
               e = rQ.pop_front();
               checkOutput("r_owner", reqRValid, e.oneHot);
               checkOutput("r_data", reqRData, e.data);
               checkOutput("r_resp", reqRResp, e.resp);
            end
         end
      end
   end

   initial begin
      addrTab[0] = 32'h1000_0000;
      addrTab[1] = 32'h1000_0100;
      addrTab[2] = 32'h8000_0010;
      addrTab[3] = 32'h1000_0300;
      addrTab[4] = 32'h1000_0400;

      // Reset state
      repeat (2) @(posedge clk);
      #4;
      checkOutput("rst_ar_valid", mstArValid, 0);
      checkOutput("rst_ar_addr", mstArAddr, 0);
      checkOutput("rst_ar_ready", reqArReady, 0);
      checkOutput("rst_full", outstFull, 0);
      checkOutput("rst_proto_err", protoErr, 0);
      checkOutput("rst_r_valid", reqRValid, 0);
      @(posedge clk);
      #2 rst = 1'b0;

      // Single request from requester 2
      grantQ.push_back(2);
      arQ.push_back(32'h8000_0010);
      applyStimulus(5'b00100, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
      checkOutput("t1_ar_ready", reqArReady, 5'b00100);
      checkOutput("t1_valid_not_yet", mstArValid, 0);
      applyStimulus(5'b00000, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
      checkOutput("t1_mst_valid", mstArValid, 1);
      checkOutput("t1_mst_addr", mstArAddr, 32'h8000_0010);
      rQ.push_back('{5'b00100, 32'h0000_CAFE, OKAY});
      applyStimulus(5'b00000, 1'b1, 1'b1, 32'h0000_CAFE, OKAY, 5'h1f);
      checkOutput("t1_r_valid", reqRValid, 5'b00100);
      applyStimulus(5'b00000, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
      checkOutput("t1_proto_err", protoErr, 0);

      // Soft clear returns rr_ptr to 0, then all five requesters compete
      @(posedge clk);
      #2 clr = 1'b1;
      @(posedge clk);
      #2 clr = 1'b0;
      spacingOn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         grantQ.push_back(k % 5);
         arQ.push_back(addrTab[k % 5]);
         rQ.push_back('{5'(5'b1 << (k % 5)), 32'h1000 + 32'(k), OKAY});
      end
      for (int c = 0; c <= 12; c++) begin
         applyStimulus((c < 12) ? 5'h1f : 5'h00, 1'b1, (c >= 2) && (c % 2 == 0),
                       (c >= 2) ? 32'h1000 + 32'(c / 2 - 1) : 32'h0, OKAY, 5'h1f);
      end
      spacingOn = 1'b0;
      checkOutput("t2_proto_err", protoErr, 0);

      // No responses: four grants fill the FIFO, the fifth must wait for a pop
      for (int k = 1; k <= 4; k++) begin
         grantQ.push_back(k);
         arQ.push_back(addrTab[k]);
      end
      for (int c = 0; c < 8; c++) applyStimulus(5'h1f, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
      for (int c = 8; c < 11; c++) begin
         applyStimulus(5'h1f, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
         checkOutput("t3_full", outstFull, 1);
         checkOutput("t3_no_grant", reqArReady, 0);
      end
      rQ.push_back('{5'b00010, 32'h0000_D001, OKAY});
      applyStimulus(5'h1f, 1'b1, 1'b1, 32'h0000_D001, OKAY, 5'h1f);
      checkOutput("t3_no_bypass", reqArReady, 0);
      grantQ.push_back(0);
      arQ.push_back(addrTab[0]);
      applyStimulus(5'h1f, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
      checkOutput("t3_grant_after_pop", reqArReady, 5'b00001);
      checkOutput("t3_not_full", outstFull, 0);

      // Master AR stalled for three cycles
      for (int c = 0; c < 3; c++) begin
         applyStimulus(5'h1f, 1'b0, 1'b0, 32'h0, OKAY, 5'h1f);
         checkOutput("t4_valid_stable", mstArValid, 1);
         checkOutput("t4_addr_stable", mstArAddr, addrTab[0]);
         checkOutput("t4_ready_low", reqArReady, 0);
      end
      applyStimulus(5'h00, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);

      // Head requester (2) not ready: beat held, then SLVERR forwarded
      for (int c = 0; c < 2; c++) begin
         applyStimulus(5'h00, 1'b1, 1'b1, 32'h0000_BAD0, SLVERR, 5'b11011);
         checkOutput("t5_mst_r_ready", mstRReady, 0);
         checkOutput("t5_r_valid_head", reqRValid, 5'b00100);
         checkOutput("t5_resp", reqRResp, 2'b10);
         checkOutput("t5_still_full", outstFull, 1);
      end
      rQ.push_back('{5'b00100, 32'h0000_BAD0, SLVERR});
      applyStimulus(5'h00, 1'b1, 1'b1, 32'h0000_BAD0, SLVERR, 5'h1f);
      rQ.push_back('{5'b01000, 32'h0000_D003, OKAY});
      applyStimulus(5'h00, 1'b1, 1'b1, 32'h0000_D003, OKAY, 5'h1f);
      rQ.push_back('{5'b10000, 32'h0000_D004, OKAY});
      applyStimulus(5'h00, 1'b1, 1'b1, 32'h0000_D004, OKAY, 5'h1f);
      rQ.push_back('{5'b00001, 32'h0000_D000, OKAY});
      applyStimulus(5'h00, 1'b1, 1'b1, 32'h0000_D000, OKAY, 5'h1f);
      applyStimulus(5'h00, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
      checkOutput("t5_drained", outstFull, 0);

      // rr_ptr advanced only at the stalled handshake, so requester 1 is next
      grantQ.push_back(1);
      arQ.push_back(addrTab[1]);
      applyStimulus(5'h1f, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
      checkOutput("t4_rr_after_stall", reqArReady, 5'b00010);
      applyStimulus(5'h00, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
      rQ.push_back('{5'b00010, 32'h0000_E001, OKAY});
      applyStimulus(5'h00, 1'b1, 1'b1, 32'h0000_E001, OKAY, 5'h1f);
      applyStimulus(5'h00, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);

      // Stray R beat with nothing outstanding
      applyStimulus(5'h00, 1'b1, 1'b1, 32'h0000_DEAD, OKAY, 5'h1f);
      checkOutput("t6_stray_ready", mstRReady, 0);
      checkOutput("t6_stray_valid", reqRValid, 0);
      applyStimulus(5'h00, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
      checkOutput("t6_proto_err", protoErr, 1);
      applyStimulus(5'h00, 1'b1, 1'b0, 32'h0, OKAY, 5'h1f);
      checkOutput("t6_proto_sticky", protoErr, 1);

      // Async reset while an AR is being issued
      grantQ.push_back(3);
      applyStimulus(5'b01000, 1'b0, 1'b0, 32'h0, OKAY, 5'h1f);
      checkOutput("t6_grant3", reqArReady, 5'b01000);
      applyStimulus(5'h00, 1'b0, 1'b0, 32'h0, OKAY, 5'h1f);
      checkOutput("t6_issuing", mstArValid, 1);
      rst = 1'b1;
      #2;
      checkOutput("t6_rst_ar_valid", mstArValid, 0);
      checkOutput("t6_rst_ar_addr", mstArAddr, 0);
      checkOutput("t6_rst_ar_ready", reqArReady, 0);
      checkOutput("t6_rst_proto_err", protoErr, 0);
      checkOutput("t6_rst_full", outstFull, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      #2;
      checkOutput("t6_post_rst_valid", mstArValid, 0);

      checkOutput("grant_queue_empty", grantQ.size(), 0);
      checkOutput("ar_queue_empty", arQ.size(), 0);
      checkOutput("r_queue_empty", rQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
      $finish;
   end

endmodule
